// File: rtl/i2s_rx.sv
// I2S receiver: MSB-justified capture of left/right slots, one-bit-delay framing, pair delivery.
// Optional `I2S_RX_FRAMECHK_EN enables sticky frame_err and rejection of pairs with malformed slots.
module i2s_rx #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             sclk,
    input  logic             rst,
    input  logic             ws,
    input  logic             sdata,
    output logic [WIDTH-1:0] left_chan,
    output logic [WIDTH-1:0] right_chan,
    output logic             valid,
    output logic             frame_err
);

    localparam int unsigned PW    = 8;
    localparam logic [PW-1:0] P_MAX = 8'hFF;

    typedef enum logic [1:0] {PRIME, SYNC, RECV} state_t;

    state_t           state;
    logic             ws_d;
    logic [PW-1:0]    p;
    logic [WIDTH-1:0] cap;
    logic [WIDTH-1:0] staging;
    logic             staged;
    logic             left_bad;

    logic             trans_c;
    logic [PW:0]      pos_c;
    logic [WIDTH-1:0] word_c;
    logic             bad_c;

    // Current bit lands at position p+1; merge it into the capture when it fits.
    always_comb begin
        trans_c = (ws != ws_d);
        pos_c   = {1'b0, p} + 9'd1;
        word_c  = cap;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (pos_c == 9'(int'(WIDTH) - i)) begin
                word_c[i] = sdata;
            end
        end
    end

`ifdef I2S_RX_FRAMECHK_EN
    localparam logic [PW-1:0] P_WF = PW'(WIDTH - 1);
    assign bad_c = (p != P_WF);
`else
    assign bad_c = 1'b0;
    assign frame_err = 1'b0;
`endif

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state      <= PRIME;
            ws_d       <= 1'b0;
            p          <= '0;
            cap        <= '0;
            staging    <= '0;
            staged     <= 1'b0;
            left_bad   <= 1'b0;
            left_chan  <= '0;
            right_chan <= '0;
            valid      <= 1'b0;
`ifdef I2S_RX_FRAMECHK_EN
            frame_err  <= 1'b0;
`endif
        end else begin
            valid <= 1'b0;
            ws_d  <= ws;
            case (state)
                PRIME: state <= SYNC;
                SYNC: begin
                    if (trans_c) begin
                        p      <= '0;
                        cap    <= '0;
                        staged <= 1'b0;
                        state  <= RECV;
                    end
                end
                RECV: begin
                    if (trans_c) begin
                        p   <= '0;
                        cap <= '0;
`ifdef I2S_RX_FRAMECHK_EN
                        if (bad_c) frame_err <= 1'b1;
`endif
                        if (ws_d) begin
                            staging  <= word_c;
                            staged   <= 1'b1;
                            left_bad <= bad_c;
                        end else if (staged && !left_bad && !bad_c) begin
                            left_chan  <= staging;
                            right_chan <= word_c;
                            valid      <= 1'b1;
                        end
                    end else begin
                        cap <= word_c;
                        if (p != P_MAX) p <= p + 8'd1;
                    end
                end
                default: state <= PRIME;
            endcase
        end
    end

endmodule

// File: tb/tb_i2s_rx.sv
// Directed self-checking bench for i2s_rx (WIDTH=16), default and I2S_RX_FRAMECHK_EN builds.
module tb_i2s_rx;

    localparam int unsigned WIDTH = 16;

    logic             sclk  = 1'b0;
    logic             rst   = 1'b1;
    logic             ws    = 1'b0;
    logic             sdata = 1'b0;
    logic [WIDTH-1:0] left_chan;
    logic [WIDTH-1:0] right_chan;
    logic             valid;
    logic             frame_err;

    int tests = 0;
    int fails = 0;
    int edge_n = 0;
    int vcnt = 0;
    int last_edge = 0;
    int last_gap = 0;

    i2s_rx #(.WIDTH(WIDTH)) dut (
        .sclk(sclk), .rst(rst), .ws(ws), .sdata(sdata),
        .left_chan(left_chan), .right_chan(right_chan),
        .valid(valid), .frame_err(frame_err)
    );

    always #5 sclk = ~sclk;

    always @(posedge sclk) edge_n <= edge_n + 1;

    // Count valid pulses and the edge spacing between them.
    always @(negedge sclk) begin
        if (valid === 1'b1) begin
            vcnt      <= vcnt + 1;
            last_gap  <= edge_n - last_edge;
            last_edge <= edge_n;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic w, input logic d);
        ws    = w;
        sdata = d;
        @(negedge sclk);
    endtask

    // The LSB of a slot goes out with the next slot's ws value.
    task automatic send_slot(input logic w, input logic wn, input logic [31:0] data, input int n);
        for (int i = 0; i < n; i++) send_bit((i == n - 1) ? wn : w, data[n-1-i]);
    endtask

    task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int nl, input int nr);
        send_slot(1'b1, 1'b0, l, nl);
        send_slot(1'b0, 1'b1, r, nr);
    endtask

    initial begin
        int v0;
        logic [31:0] al;

        repeat (3) @(negedge sclk);
        #1;
        check("reset_left", 32'(left_chan), 32'h0);
        check("reset_right", 32'(right_chan), 32'h0);
        check("reset_valid", 32'(valid), 32'h0);
        check("reset_err", 32'(frame_err), 32'h0);

        rst = 1'b0;
        v0 = vcnt;
        repeat (3) send_frame(32'h8001, 32'h7FFE, 16, 16);
        #1;
        check("wf_left", 32'(left_chan), 32'h8001);
        check("wf_right", 32'(right_chan), 32'h7FFE);
        check("wf_valid_on_lsb_edge", 32'(valid), 32'h1);
        check("wf_pulses", 32'(vcnt - v0), 32'd2);
        check("wf_gap", 32'(last_gap), 32'd32);
        check("wf_err", 32'(frame_err), 32'h0);

        v0 = vcnt;
        send_frame(32'hABCDFF, 32'h123400, 24, 24);
        #1;
`ifdef I2S_RX_FRAMECHK_EN
        check("long_left", 32'(left_chan), 32'h8001);
        check("long_right", 32'(right_chan), 32'h7FFE);
        check("long_pulses", 32'(vcnt - v0), 32'd0);
        check("long_err", 32'(frame_err), 32'h1);
`else
        check("long_left", 32'(left_chan), 32'hABCD);
        check("long_right", 32'(right_chan), 32'h1234);
        check("long_pulses", 32'(vcnt - v0), 32'd1);
        check("long_err", 32'(frame_err), 32'h0);
`endif

        v0 = vcnt;
        send_frame(32'h5A5A, 32'hFFF, 16, 12);
        #1;
`ifdef I2S_RX_FRAMECHK_EN
        check("short_left", 32'(left_chan), 32'h8001);
        check("short_right", 32'(right_chan), 32'h7FFE);
        check("short_pulses", 32'(vcnt - v0), 32'd0);
        check("short_err", 32'(frame_err), 32'h1);
`else
        check("short_left", 32'(left_chan), 32'h5A5A);
        check("short_right", 32'(right_chan), 32'hFFF0);
        check("short_pulses", 32'(vcnt - v0), 32'd1);
        check("short_err", 32'(frame_err), 32'h0);
`endif

        v0 = vcnt;
        send_frame(32'h1357, 32'h2468, 16, 16);
        #1;
        check("recover_left", 32'(left_chan), 32'h1357);
        check("recover_right", 32'(right_chan), 32'h2468);
        check("recover_pulses", 32'(vcnt - v0), 32'd1);

        // Reset for one edge in the middle of a left slot.
        for (int i = 0; i < 8; i++) send_bit(1'b1, i[0]);
        rst = 1'b1;
        #1;
        check("midrst_left", 32'(left_chan), 32'h0);
        check("midrst_right", 32'(right_chan), 32'h0);
        check("midrst_valid", 32'(valid), 32'h0);
        check("midrst_err", 32'(frame_err), 32'h0);
        @(negedge sclk);
        rst = 1'b0;
        v0 = vcnt;
        send_frame(32'h1111, 32'h2222, 16, 16);
        #1;
        check("resync_swallow_pulses", 32'(vcnt - v0), 32'd0);
        check("resync_swallow_left", 32'(left_chan), 32'h0);
        send_frame(32'h4444, 32'h8888, 16, 16);
        #1;
        check("resync_left", 32'(left_chan), 32'h4444);
        check("resync_right", 32'(right_chan), 32'h8888);
        check("resync_pulses", 32'(vcnt - v0), 32'd1);

        v0 = vcnt;
        repeat (300) send_bit(1'b1, 1'b0);
        #1;
        check("hold_pulses", 32'(vcnt - v0), 32'd0);
        check("hold_err", 32'(frame_err), 32'h0);
        send_frame(32'hC3C3, 32'h3C3C, 16, 16);
        #1;
`ifdef I2S_RX_FRAMECHK_EN
        check("resume_left", 32'(left_chan), 32'h4444);
        check("resume_right", 32'(right_chan), 32'h8888);
        check("resume_pulses", 32'(vcnt - v0), 32'd0);
        check("resume_err", 32'(frame_err), 32'h1);
`else
        check("resume_left", 32'(left_chan), 32'h0000);
        check("resume_right", 32'(right_chan), 32'h3C3C);
        check("resume_pulses", 32'(vcnt - v0), 32'd1);
        check("resume_err", 32'(frame_err), 32'h0);
`endif
        v0 = vcnt;
        send_frame(32'h0F0F, 32'hF0F0, 16, 16);
        #1;
        check("resume2_left", 32'(left_chan), 32'h0F0F);
        check("resume2_right", 32'(right_chan), 32'hF0F0);
        check("resume2_pulses", 32'(vcnt - v0), 32'd1);

        for (int k = 0; k < 4; k++) begin
            al = (k % 2 == 0) ? 32'h0000 : 32'hFFFF;
            v0 = vcnt;
            send_frame(al, al ^ 32'hFFFF, 16, 16);
            #1;
            check($sformatf("alt%0d_left", k), 32'(left_chan), al);
            check($sformatf("alt%0d_right", k), 32'(right_chan), al ^ 32'hFFFF);
            check($sformatf("alt%0d_gap", k), 32'(last_gap), 32'd32);
            check($sformatf("alt%0d_pulses", k), 32'(vcnt - v0), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
